// File: rtl/stack_replay_if.sv
// Handshake bundle between the replay sequencer, its controller and the symbol stack.
interface stack_replay_if #(
  parameter int DATA_WIDTH = 2
);
  logic                  start;
  logic                  abort;
  logic                  stk_empty;
  logic [DATA_WIDTH-1:0] stk_data;
  logic                  stk_pop;
  logic [DATA_WIDTH-1:0] sym_out;
  logic                  sym_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, abort, stk_empty, stk_data,
    input  stk_pop, sym_out, sym_valid, busy, done
  );

  modport slave (
    input  start, abort, stk_empty, stk_data,
    output stk_pop, sym_out, sym_valid, busy, done
  );
endinterface

// File: rtl/stack_replay.sv
// Pops the symbol stack newest-first and presents each symbol for a fixed
// on-time followed by a blank gap, for slow LED/tone playback logic.
module stack_replay #(
  parameter int DATA_WIDTH = 2,
  parameter int ON_CYCLES  = 8,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  stack_replay_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] ON_LOAD  = CNT_WIDTH'(ON_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD = CNT_WIDTH'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    SHOW,
    GAP,
    FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  counter_q, counter_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] sym_out_q, sym_out_d;
  logic                  sym_valid_q, sym_valid_d;
  logic                  stk_pop_q, stk_pop_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      last_q      <= 1'b0;
      sym_out_q   <= '0;
      sym_valid_q <= 1'b0;
      stk_pop_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      last_q      <= last_d;
      sym_out_q   <= sym_out_d;
      sym_valid_q <= sym_valid_d;
      stk_pop_q   <= stk_pop_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Outputs are computed for the state being entered so that every output is a flop.
  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    last_d      = last_q;
    sym_out_d   = sym_out_q;
    sym_valid_d = sym_valid_q;
    stk_pop_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          if (!bus.stk_empty) begin
            state_d   = POP;
            stk_pop_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      POP: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        sym_out_d   = bus.stk_data;
        sym_valid_d = 1'b1;
        last_d      = bus.stk_empty;
        counter_d   = ON_LOAD;
        state_d     = SHOW;
      end
      SHOW: begin
        if (counter_q == '0) begin
          sym_valid_d = 1'b0;
          counter_d   = GAP_LOAD;
          state_d     = GAP;
        end else begin
          counter_d = counter_q - 1'b1;
        end
      end
      GAP: begin
        if (counter_q == '0) begin
          // The live empty flag is rechecked so a pop is never issued on an empty stack.
          if (last_q || bus.stk_empty) begin
            state_d = FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d   = POP;
            stk_pop_d = 1'b1;
          end
        end else begin
          counter_d = counter_q - 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (bus.abort && state_q != IDLE && state_q != FINISH) begin
      state_d     = IDLE;
      stk_pop_d   = 1'b0;
      sym_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      counter_d   = '0;
    end
  end

  assign bus.stk_pop   = stk_pop_q;
  assign bus.sym_out   = sym_out_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_stack_replay.sv
// Bench for stack_replay: a behavioural 16-deep stack feeds the DUT, and a
// scoreboard of expected LIFO symbols is checked as each symbol appears.
module tb_stack_replay;

  localparam int ON_C  = 8;
  localparam int GAP_C = 4;

  logic clk;
  logic rst_n;

  stack_replay_if #(.DATA_WIDTH(2)) bus ();

  stack_replay #(
    .DATA_WIDTH(2),
    .ON_CYCLES (ON_C),
    .GAP_CYCLES(GAP_C),
    .CNT_WIDTH (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] mem [16];
  logic [4:0] stk_count;
  logic [1:0] stk_dout;
  logic       push_en;
  logic [1:0] push_val;
  logic       pop_on_empty;

  // Popping registers the removed entry onto DATA_OUT, as the real stack does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_count    <= '0;
      stk_dout     <= '0;
      pop_on_empty <= 1'b0;
    end else if (bus.stk_pop) begin
      if (stk_count == 5'd0) begin
        pop_on_empty <= 1'b1;
      end else begin
        stk_dout  <= mem[4'(stk_count - 5'd1)];
        stk_count <= stk_count - 5'd1;
      end
    end else if (push_en && stk_count < 5'd16) begin
      stk_count <= stk_count + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !bus.stk_pop && push_en && stk_count < 5'd16) begin
      mem[4'(stk_count)] <= push_val;
    end
  end

  assign bus.stk_empty = (stk_count == 5'd0);
  assign bus.stk_data  = stk_dout;

  int         checks;
  int         errors;
  logic [1:0] sb [$];

  typedef struct {
    int n;
    int base;
    bit mid_start;
    int exp_cycles;
  } vec_t;

  vec_t vecs [5];

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_values(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      push_en  = 1'b1;
      push_val = 2'((base + i) % 4);
      @(negedge clk);
    end
    push_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic apply_stimulus();
    for (int i = int'(stk_count) - 1; i >= 0; i--) begin
      sb.push_back(mem[4'(i)]);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_replay(input int exp_pops, input int exp_cycles, input bit mid_start);
    int cyc = 0;
    int pops = 0;
    int rises = 0;
    int busy_err = 0;
    int hi_len = 0;
    int lo_len = 0;
    int pop_len = 0;
    int full_check_at = -1;
    bit prev_v = 1'b0;
    bit prev_p = 1'b0;
    bit restarted = 1'b0;
    bit got_done = 1'b0;
    while (cyc < 400) begin
      if (bus.start) bus.start = 1'b0;
      if (bus.stk_pop) begin
        pop_len++;
        if (!prev_p) begin
          pops++;
          if (pops == 1) full_check_at = cyc + 1;
        end
      end else if (prev_p) begin
        check_output("pop_width", pop_len, 1);
        pop_len = 0;
      end
      if (cyc == full_check_at) check_output("count_after_first_pop", int'(stk_count), exp_pops - 1);
      if (bus.sym_valid && !prev_v) begin
        rises++;
        if (rises > 1) check_output("gap_len", lo_len, GAP_C + 2);
        if (sb.size() > 0) check_output("sym_out", int'(bus.sym_out), int'(sb.pop_front()));
        else check_output("symbols_seen", rises, exp_pops);
        hi_len = 1;
      end else if (bus.sym_valid) begin
        hi_len++;
      end else if (prev_v) begin
        check_output("on_len", hi_len, ON_C);
        lo_len = 1;
        if (mid_start && !restarted) begin
          bus.start = 1'b1;
          restarted = 1'b1;
        end
      end else begin
        lo_len++;
      end
      if (bus.done) begin
        if (bus.busy) busy_err++;
        got_done = 1'b1;
        break;
      end
      if (bus.busy != (exp_pops > 0)) busy_err++;
      prev_v = bus.sym_valid;
      prev_p = bus.stk_pop;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check_output("done_seen", int'(got_done), 1);
    check_output("done_cycle", cyc, exp_cycles);
    check_output("pop_count", pops, exp_pops);
    check_output("symbol_count", rises, exp_pops);
    check_output("sb_left", sb.size(), 0);
    check_output("busy_errors", busy_err, 0);
    check_output("stk_empty_end", int'(bus.stk_empty), 1);
    check_output("pop_on_empty", int'(pop_on_empty), 0);
    @(negedge clk);
    check_output("done_single", int'(bus.done), 0);
    check_output("busy_after", int'(bus.busy), 0);
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    int pop_cnt;

    vecs[0] = '{n: 3,  base: 1, mid_start: 1'b0, exp_cycles: 42};
    vecs[1] = '{n: 0,  base: 0, mid_start: 1'b0, exp_cycles: 0};
    vecs[2] = '{n: 16, base: 0, mid_start: 1'b0, exp_cycles: 224};
    vecs[3] = '{n: 4,  base: 2, mid_start: 1'b1, exp_cycles: 56};
    vecs[4] = '{n: 1,  base: 3, mid_start: 1'b0, exp_cycles: 14};

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    push_en   = 1'b0;
    push_val  = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_sym_out", int'(bus.sym_out), 0);
    check_output("rst_sym_valid", int'(bus.sym_valid), 0);
    check_output("rst_stk_pop", int'(bus.stk_pop), 0);
    check_output("rst_busy", int'(bus.busy), 0);
    check_output("rst_done", int'(bus.done), 0);

    for (int v = 0; v < 5; v++) begin
      $display("[TB] vector %0d: %0d entries", v, vecs[v].n);
      push_values(vecs[v].n, vecs[v].base);
      check_output("pushed_count", int'(stk_count), vecs[v].n);
      apply_stimulus();
      run_replay(vecs[v].n, vecs[v].exp_cycles, vecs[v].mid_start);
    end

    $display("[TB] abort in third SHOW cycle of first symbol");
    push_values(4, 0);
    apply_stimulus();
    repeat (4) @(negedge clk);
    check_output("abort_pre_valid", int'(bus.sym_valid), 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_output("abort_valid", int'(bus.sym_valid), 0);
    check_output("abort_busy", int'(bus.busy), 0);
    check_output("abort_sym_kept", int'(bus.sym_out), 3);
    sb.delete();
    done_cnt = 0;
    pop_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      done_cnt += int'(bus.done);
      pop_cnt  += int'(bus.stk_pop);
      @(negedge clk);
    end
    check_output("abort_no_done", done_cnt, 0);
    check_output("abort_no_pop", pop_cnt, 0);
    check_output("abort_stack_left", int'(stk_count), 3);
    apply_stimulus();
    run_replay(3, 42, 1'b0);

    $display("[TB] start with abort while idle");
    push_values(2, 3);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    pop_cnt  = 0;
    for (int i = 0; i < 5; i++) begin
      done_cnt += int'(bus.done);
      busy_cnt += int'(bus.busy);
      pop_cnt  += int'(bus.stk_pop);
      @(negedge clk);
    end
    check_output("idle_abort_done", done_cnt, 0);
    check_output("idle_abort_busy", busy_cnt, 0);
    check_output("idle_abort_pop", pop_cnt, 0);
    check_output("idle_abort_stack", int'(stk_count), 2);
    apply_stimulus();
    run_replay(2, 28, 1'b0);

    $display("[TB] asynchronous reset during SHOW");
    push_values(2, 1);
    apply_stimulus();
    repeat (3) @(negedge clk);
    check_output("pre_reset_valid", int'(bus.sym_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("areset_valid", int'(bus.sym_valid), 0);
    check_output("areset_busy", int'(bus.busy), 0);
    check_output("areset_sym_out", int'(bus.sym_out), 0);
    check_output("areset_pop", int'(bus.stk_pop), 0);
    check_output("areset_done", int'(bus.done), 0);
    check_output("areset_empty", int'(bus.stk_empty), 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus();
    run_replay(0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
